// File: rtl/exit_gate_controller.sv
// Exit gate controller: opens the exit barrier for a departing car and
// owns the lot free-space count (entry decrements, exit credits).
module exit_gate_controller #(
  parameter int WIDTH       = 4,
  parameter int CAPACITY    = 10,
  parameter int OPEN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             exit_sensor,
  input  logic             space_taken,
  input  logic             clear_error,
  output logic             gate_open,
  output logic [WIDTH-1:0] free_count,
  output logic             lot_empty,
  output logic             exit_error
);

  localparam int TW =
    (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
  localparam logic [WIDTH-1:0] CAP = WIDTH'(CAPACITY);
  localparam logic [TW-1:0] TLAST = TW'(OPEN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    OPEN,
    WAIT_CLEAR,
    CREDIT
  } state_t;

  state_t           state;
  logic [TW-1:0]    timer;

  logic [WIDTH-1:0] inc_sum;
  logic [WIDTH-1:0] dec_dif;
  logic [WIDTH-1:0] next_count;
  logic             carry;
  logic             borrow;
  logic             at_cap;
  logic             at_zero;
  logic             inc;
  logic             dec;
  logic             error_set;

  // +1 ripple-carry chain and -1 borrow chain
  always_comb begin
    carry  = 1'b1;
    borrow = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      inc_sum[i] = free_count[i] ^ carry;
      carry      = free_count[i] & carry;
      dec_dif[i] = free_count[i] ^ borrow;
      borrow     = ~free_count[i] & borrow;
    end
  end

  assign at_cap  = (free_count == CAP);
  assign at_zero = (free_count == '0);
  assign inc     = (state == CREDIT);
  assign dec     = space_taken;

  // Both at once cancel, so the count holds
  always_comb begin
    next_count = free_count;
    if (inc && !dec && !at_cap)
      next_count = inc_sum;
    else if (dec && !inc && !at_zero)
      next_count = dec_dif;
  end

  assign error_set =
    (state == IDLE) && exit_sensor && at_cap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      gate_open  <= 1'b0;
      free_count <= CAP;
      lot_empty  <= 1'b1;
      exit_error <= 1'b0;
    end else begin
      free_count <= next_count;
      lot_empty  <= (next_count == CAP);
      if (error_set)
        exit_error <= 1'b1;
      else if (clear_error)
        exit_error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (exit_sensor && !at_cap) begin
            state     <= OPEN;
            timer     <= '0;
            gate_open <= 1'b1;
          end
        end
        OPEN: begin
          if (timer == TLAST)
            state <= WAIT_CLEAR;
          else
            timer <= timer + 1'b1;
        end
        WAIT_CLEAR: begin
          if (!exit_sensor) begin
            state     <= CREDIT;
            gate_open <= 1'b0;
          end
        end
        CREDIT: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          gate_open <= 1'b0;
        end
      endcase
    end
  end

endmodule
